// File: rtl/ptw_pkg.sv
// ----------------------------------------------------------------------------
// ptw_pkg
//   Shared definitions for the page-table walker, the TLB that issues miss
//   requests, and their benches.
//   Contents:
//     VA_W, OFF_W, VPN_W  default address / offset / page-number widths
//     PTE_ENTRIES         number of page-table entries (2**VPN_W)
//     CNT_W               width of the walk latency counter (LATENCY <= 15)
//     pte_t               page-table entry {valid, ppn}
//     ptw_state_e         walker FSM states
// ----------------------------------------------------------------------------
package ptw_pkg;

  localparam int VA_W        = 8;
  localparam int OFF_W       = 4;
  localparam int VPN_W       = VA_W - OFF_W;
  localparam int PTE_ENTRIES = 1 << VPN_W;
  localparam int CNT_W       = 4;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] ppn;
  } pte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } ptw_state_e;

endpackage

// File: rtl/ptw_table.sv
// ----------------------------------------------------------------------------
// ptw_table
//   Single-level page table: 2**IDX_W entries of pte_t held in flops so the
//   whole table can be cleared by reset.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (clears every entry)
//     i_we         write strobe; entry i_widx takes i_wdata at the edge
//     i_widx       entry written
//     i_wdata      PTE written
//     i_ridx       entry read (asynchronous read)
//     o_rdata      contents of entry i_ridx as of the current cycle
// ----------------------------------------------------------------------------
module ptw_table
  import ptw_pkg::*;
#(
  parameter int IDX_W = VPN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  pte_t             i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output pte_t             o_rdata
);

  localparam int ENTRIES = 1 << IDX_W;

  pte_t r_pte [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_pte[i] <= '0;
      end
    end else if (i_we) begin
      r_pte[i_widx] <= i_wdata;
    end
  end

  // The read is combinational, so a reader that registers o_rdata on the
  // same edge as a write sees the pre-write contents (read-before-write).
  assign o_rdata = r_pte[i_ridx];

endmodule

// File: rtl/page_table_walker.sv
// ----------------------------------------------------------------------------
// page_table_walker
//   Responder on the TLB miss path. Accepts one miss request at a time,
//   waits LATENCY cycles in WALK, then looks up the PTE for the request's
//   VPN and presents either {ppn, offset} or a page fault until the TLB
//   takes it. The page table can be written in any state.
//   Optional feature macro: PTW_PERF_CNT_EN adds walk_cnt / fault_cnt.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     req_valid/req_ready     miss request handshake (req_ready = IDLE)
//     req_vaddr               virtual address to translate
//     resp_valid/resp_ready   result handshake (resp_valid = RESP)
//     resp_paddr, resp_fault  translation result; paddr is 0 on fault
//     pte_we, pte_idx,        page-table write port {valid, ppn}
//     pte_wdata
//     walk_cnt, fault_cnt     saturating completed / faulting walk counts
//                             (PTW_PERF_CNT_EN only)
//   All outputs come from registers or the state register only.
// ----------------------------------------------------------------------------
module page_table_walker #(
  parameter int VA_W    = ptw_pkg::VA_W,
  parameter int OFF_W   = ptw_pkg::OFF_W,
  parameter int LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VA_W-1:0]       req_vaddr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [VA_W-1:0]       resp_paddr,
  output logic                  resp_fault,
  input  logic                  pte_we,
  input  logic [VA_W-OFF_W-1:0] pte_idx,
  input  logic [VA_W-OFF_W:0]   pte_wdata
`ifdef PTW_PERF_CNT_EN
  ,
  output logic [15:0]           walk_cnt,
  output logic [15:0]           fault_cnt
`endif
);

  import ptw_pkg::*;

  localparam int PN_W = VA_W - OFF_W;

  ptw_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [VA_W-1:0]  r_vaddr, w_vaddr_next;
  logic [VA_W-1:0]  r_paddr, w_paddr_next;
  logic             r_fault, w_fault_next;
  logic             w_resp_done;
  pte_t             w_pte;

  ptw_table #(
    .IDX_W (PN_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (pte_we),
    .i_widx  (pte_idx),
    .i_wdata (pte_t'(pte_wdata)),
    .i_ridx  (r_vaddr[VA_W-1:OFF_W]),
    .o_rdata (w_pte)
  );

  assign req_ready   = (r_state == IDLE);
  assign resp_valid  = (r_state == RESP);
  assign resp_paddr  = r_paddr;
  assign resp_fault  = r_fault;
  assign w_resp_done = (r_state == RESP) && resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_vaddr <= '0;
      r_paddr <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_vaddr <= w_vaddr_next;
      r_paddr <= w_paddr_next;
      r_fault <= w_fault_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_vaddr_next = r_vaddr;
    w_paddr_next = r_paddr;
    w_fault_next = r_fault;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_next = WALK;
          w_vaddr_next = req_vaddr;
          // Counter runs LATENCY-1 .. 0, giving exactly LATENCY WALK cycles.
          w_cnt_next   = CNT_W'(LATENCY - 1);
        end
      end
      WALK: begin
        if (r_cnt == '0) begin
          w_state_next = RESP;
          // The result is captured here and only changes on the next walk,
          // so later table writes cannot disturb a pending response.
          if (w_pte.valid) begin
            w_paddr_next = {w_pte.ppn, r_vaddr[OFF_W-1:0]};
            w_fault_next = 1'b0;
          end else begin
            w_paddr_next = '0;
            w_fault_next = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      RESP: begin
        // Going through IDLE keeps req_ready low in the handshake cycle.
        if (w_resp_done) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

`ifdef PTW_PERF_CNT_EN
  logic [15:0] r_walk_cnt;
  logic [15:0] r_fault_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_walk_cnt  <= '0;
      r_fault_cnt <= '0;
    end else if (w_resp_done) begin
      if (r_walk_cnt != 16'hFFFF) begin
        r_walk_cnt <= r_walk_cnt + 16'd1;
      end
      if (r_fault && (r_fault_cnt != 16'hFFFF)) begin
        r_fault_cnt <= r_fault_cnt + 16'd1;
      end
    end
  end

  assign walk_cnt  = r_walk_cnt;
  assign fault_cnt = r_fault_cnt;
`endif

endmodule

// File: tb/tb_page_table_walker.sv
// ----------------------------------------------------------------------------
// tb_page_table_walker
//   Table-driven walks through a scoreboard queue, followed by hand-written
//   sequences: response backpressure, a write on the WALK->RESP edge, reset
//   during a walk, and (with PTW_PERF_CNT_EN) the performance counters.
// ----------------------------------------------------------------------------
module tb_page_table_walker;

  localparam int LATENCY = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_vaddr;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_paddr;
  logic        resp_fault;
  logic        pte_we;
  logic [3:0]  pte_idx;
  logic [4:0]  pte_wdata;
`ifdef PTW_PERF_CNT_EN
  logic [15:0] walk_cnt;
  logic [15:0] fault_cnt;
`endif

  page_table_walker #(
    .VA_W    (8),
    .OFF_W   (4),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vaddr  (req_vaddr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_paddr (resp_paddr),
    .resp_fault (resp_fault),
    .pte_we     (pte_we),
    .pte_idx    (pte_idx),
    .pte_wdata  (pte_wdata)
`ifdef PTW_PERF_CNT_EN
    ,
    .walk_cnt   (walk_cnt),
    .fault_cnt  (fault_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_write;
    logic [3:0] idx;
    logic [4:0] wdata;
    logic [7:0] vaddr;
    logic [7:0] exp_paddr;
    logic       exp_fault;
  } vec_t;

  typedef struct {
    logic [7:0] paddr;
    logic       fault;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic write_pte(input logic [3:0] idx, input logic [4:0] data);
    @(negedge clk);
    pte_we    = 1'b1;
    pte_idx   = idx;
    pte_wdata = data;
    @(negedge clk);
    pte_we    = 1'b0;
  endtask

  // One request: optional write injected so it lands on the WALK->RESP edge,
  // optional hold of resp_ready=0 for 'hold' cycles once the result is up.
  task automatic do_walk(input logic [7:0] va, input int hold, input logic inj,
                         input logic [3:0] inj_idx, input logic [4:0] inj_data);
    int   n;
    exp_t e;
    @(negedge clk);
    check($sformatf("req_ready before va=%02h", va), 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_vaddr = va;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      if (inj && n == LATENCY - 1) begin
        pte_we    = 1'b1;
        pte_idx   = inj_idx;
        pte_wdata = inj_data;
      end
      @(negedge clk);
      pte_we = 1'b0;
      n++;
    end
    check($sformatf("latency va=%02h", va), 32'(n), 32'(LATENCY));
    if (sb.size() == 0) begin
      check("scoreboard empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (resp_valid !== 1'b1) begin
      check($sformatf("resp_valid timeout va=%02h", va), 32'(resp_valid), 32'd1);
      return;
    end
    $display("walk va=%02h paddr=%02h fault=%0b (expected %02h/%0b)",
             va, resp_paddr, resp_fault, e.paddr, e.fault);
    check($sformatf("paddr va=%02h", va), 32'(resp_paddr), 32'(e.paddr));
    check($sformatf("fault va=%02h", va), 32'(resp_fault), 32'(e.fault));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("held paddr cycle %0d", h), 32'(resp_paddr), 32'(e.paddr));
      check($sformatf("held req_ready cycle %0d", h), 32'(req_ready), 32'd0);
      check($sformatf("held resp_valid cycle %0d", h), 32'(resp_valid), 32'd1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check($sformatf("resp_valid after handshake va=%02h", va), 32'(resp_valid), 32'd0);
    check($sformatf("req_ready after handshake va=%02h", va), 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    exp_t e;

    vecs[0] = '{1'b0, 4'h0, 5'h00, 8'h35, 8'h00, 1'b1};
    vecs[1] = '{1'b1, 4'h3, 5'h1A, 8'h35, 8'hA5, 1'b0};
    vecs[2] = '{1'b1, 4'h0, 5'h10, 8'h0F, 8'h0F, 1'b0};
    vecs[3] = '{1'b1, 4'hF, 5'h1F, 8'hF0, 8'hF0, 1'b0};
    vecs[4] = '{1'b1, 4'h7, 5'h0C, 8'h7B, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 4'h0, 5'h00, 8'h8E, 8'h00, 1'b1};
    vecs[6] = '{1'b1, 4'h8, 5'h13, 8'h8E, 8'h3E, 1'b0};
    vecs[7] = '{1'b0, 4'h0, 5'h00, 8'h3C, 8'hAC, 1'b0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_vaddr  = 8'h00;
    resp_ready = 1'b0;
    pte_we     = 1'b0;
    pte_idx    = 4'h0;
    pte_wdata  = 5'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_paddr", 32'(resp_paddr), 32'h00);
    check("reset resp_fault", 32'(resp_fault), 32'd0);
`ifdef PTW_PERF_CNT_EN
    check("reset walk_cnt", 32'(walk_cnt), 32'd0);
    check("reset fault_cnt", 32'(fault_cnt), 32'd0);
`endif

    // Table-driven walks.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_write) write_pte(vecs[i].idx, vecs[i].wdata);
      e.paddr = vecs[i].exp_paddr;
      e.fault = vecs[i].exp_fault;
      sb.push_back(e);
      do_walk(vecs[i].vaddr, 0, 1'b0, 4'h0, 5'h00);
    end

    // Backpressure: result stays put for 5 cycles with resp_ready low.
    e.paddr = 8'hA5; e.fault = 1'b0; sb.push_back(e);
    do_walk(8'h35, 5, 1'b0, 4'h0, 5'h00);

    // Write to the entry being read on the WALK->RESP edge: old value wins.
    e.paddr = 8'hA5; e.fault = 1'b0; sb.push_back(e);
    do_walk(8'h35, 0, 1'b1, 4'h3, 5'h17);
    e.paddr = 8'h75; e.fault = 1'b0; sb.push_back(e);
    do_walk(8'h35, 0, 1'b0, 4'h0, 5'h00);

    // Reset in the middle of a walk.
    @(negedge clk);
    req_valid = 1'b1;
    req_vaddr = 8'h35;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid-walk reset resp_valid", 32'(resp_valid), 32'd0);
    check("mid-walk reset req_ready", 32'(req_ready), 32'd1);
    check("mid-walk reset resp_paddr", 32'(resp_paddr), 32'h00);
    check("mid-walk reset resp_fault", 32'(resp_fault), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    check("no response after mid-walk reset", 32'(seen), 32'd0);
`ifdef PTW_PERF_CNT_EN
    check("walk_cnt after reset", 32'(walk_cnt), 32'd0);
    check("fault_cnt after reset", 32'(fault_cnt), 32'd0);
`endif
    e.paddr = 8'h00; e.fault = 1'b1; sb.push_back(e);
    do_walk(8'h35, 0, 1'b0, 4'h0, 5'h00);

`ifdef PTW_PERF_CNT_EN
    // Three walks since reset, one of them (the one above) faulting.
    write_pte(4'h3, 5'h1A);
    e.paddr = 8'hA5; e.fault = 1'b0; sb.push_back(e);
    do_walk(8'h35, 0, 1'b0, 4'h0, 5'h00);
    e.paddr = 8'hAF; e.fault = 1'b0; sb.push_back(e);
    do_walk(8'h3F, 0, 1'b0, 4'h0, 5'h00);
    check("walk_cnt after 3 walks", 32'(walk_cnt), 32'd3);
    check("fault_cnt after 3 walks", 32'(fault_cnt), 32'd1);
`endif

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
